pulse_gen: RTL and testbench

Programmable pulse-train generator. It is the producing end of the edge/pulse interface: it turns a one-cycle trigger into a train of `count_i` pulses, each `high_len_i` cycles high and separated by `low_len_i` cycles low. Downstream edge/pulse detectors consume its output. It sits beside the edge-detection blocks and drives strobes, enables and test patterns; `busy_o` and `done_o` handshake with the requester.

---
 rtl/pulse_gen_pkg.sv | 12 +
 rtl/pulse_gen.sv | 103 ++++++++++
 tb/tb_pulse_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse_gen programmable pulse-train generator.
package pulse_gen_pkg;

  localparam int PG_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pg_state_e;

endpackage

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: one trigger yields count_i pulses of high_len_i cycles
// separated by low_len_i cycles. Optional abort input enabled by `define PULSE_GEN_ABORT_EN.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = PG_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [CNT_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] low_len_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
`ifdef PULSE_GEN_ABORT_EN
  ,
  input  logic             abort_i
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pg_state_e        state;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] high_clamped;
  logic [CNT_W-1:0] low_clamped;
  logic             abort;

`ifdef PULSE_GEN_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // A zero length would otherwise underflow the reload value, so it is treated as one cycle.
  assign high_clamped = (high_len_i == '0) ? ONE : high_len_i;
  assign low_clamped  = (low_len_i == '0) ? ONE : low_len_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      high_len <= '0;
      low_len  <= '0;
      hcnt     <= '0;
      lcnt     <= '0;
      rem      <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i && !abort) begin
              high_len <= high_clamped;
              low_len  <= low_clamped;
              if (count_i != '0) begin
                state <= HIGH;
                hcnt  <= high_clamped - ONE;
                rem   <= count_i - ONE;
              end else begin
                done_o <= 1'b1;
              end
            end
          end
          HIGH: begin
            if (hcnt != '0) begin
              hcnt <= hcnt - ONE;
            end else if (rem == '0) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end else begin
              state <= LOW;
              lcnt  <= low_len - ONE;
            end
          end
          LOW: begin
            // Reloading hcnt here keeps the next pulse exactly high_len cycles wide.
            if (lcnt != '0) begin
              lcnt <= lcnt - ONE;
            end else begin
              state <= HIGH;
              hcnt  <= high_len - ONE;
              rem   <= rem - ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pulse_o = (state == HIGH);
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: directed and random trains against an arithmetic waveform model.
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] high_len_i = '0;
  logic [7:0] low_len_i = '0;
  logic [7:0] count_i = '0;
  logic       pulse_o;
  logic       busy_o;
  logic       done_o;
`ifdef PULSE_GEN_ABORT_EN
  logic       abort_i = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rises = 0;
  logic prev_pulse = 1'b0;

  // Model of the accepted train: the waveform is a pure function of the cycle offset.
  bit have = 1'b0;
  int acc_cyc = 0;
  int mh = 1;
  int ml = 1;
  int mc = 0;

  pulse_gen dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start_i),
    .high_len_i(high_len_i),
    .low_len_i (low_len_i),
    .count_i   (count_i),
    .pulse_o   (pulse_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
`ifdef PULSE_GEN_ABORT_EN
    ,
    .abort_i   (abort_i)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model(input int c, output logic p, output logic b, output logic d);
    int u;
    int total;
    p = 1'b0;
    b = 1'b0;
    d = 1'b0;
    if (have && (c > acc_cyc)) begin
      u     = c - acc_cyc - 1;
      total = (mc == 0) ? 0 : mc * mh + (mc - 1) * ml;
      b     = (u < total);
      p     = b && ((u % (mh + ml)) < mh);
      d     = (u == total);
    end
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance one clock, and compare all outputs with the model.
  task automatic step(input logic st, input int h, input int l, input int c, input logic ab);
    logic p, b, d;
    model(cyc, p, b, d);
    start_i    = st;
    high_len_i = 8'(h);
    low_len_i  = 8'(l);
    count_i    = 8'(c);
`ifdef PULSE_GEN_ABORT_EN
    abort_i = ab;
`endif
    if (ab && b) begin
      have = 1'b0;
    end else if (st && !ab && !b) begin
      have    = 1'b1;
      acc_cyc = cyc;
      mh      = (h == 0) ? 1 : h;
      ml      = (l == 0) ? 1 : l;
      mc      = c;
    end
    @(posedge clk);
    cyc++;
    #1;
    model(cyc, p, b, d);
    check_bit("pulse", pulse_o, p);
    check_bit("busy", busy_o, b);
    check_bit("done", done_o, d);
    if (pulse_o === 1'b1 && prev_pulse !== 1'b1) rises++;
    prev_pulse = pulse_o;
  endtask

  task automatic idle_until_done(input int bound);
    int n = 0;
    while (done_o !== 1'b1 && n < bound) begin
      step(1'b0, 0, 0, 0, 1'b0);
      n++;
    end
    check_bit("done_reached", done_o, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p, b, d;
    #1 resetn = 1'b0;
    #1;
    check_bit("reset_pulse", pulse_o, 1'b0);
    check_bit("reset_busy", busy_o, 1'b0);
    check_bit("reset_done", done_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    idle_cycles(2);

    // Basic train H=3 L=2 count=2.
    rises = 0;
    step(1'b1, 3, 2, 2, 1'b0);
    idle_until_done(20);
    check_int("basic_pulses", rises, 2);
    idle_cycles(2);

    // Zero count: immediate done, no pulse.
    step(1'b1, 4, 4, 0, 1'b0);
    check_bit("zero_count_done", done_o, 1'b1);
    idle_cycles(2);

    // Zero lengths clamp to one cycle each.
    rises = 0;
    step(1'b1, 0, 0, 3, 1'b0);
    idle_until_done(20);
    check_int("clamp_pulses", rises, 3);

    // Back-to-back: start in the done cycle, then start while busy with other lengths.
    step(1'b1, 2, 3, 2, 1'b0);
    check_bit("b2b_pulse", pulse_o, 1'b1);
    step(1'b1, 7, 1, 5, 1'b0);
    step(1'b1, 7, 1, 5, 1'b0);
    idle_until_done(30);
    idle_cycles(2);

    // Long phases and many pulses, checking counters never wrap.
    rises = 0;
    step(1'b1, 255, 255, 3, 1'b0);
    idle_until_done(2000);
    check_int("max_len_pulses", rises, 3);
    rises = 0;
    step(1'b1, 2, 1, 255, 1'b0);
    idle_until_done(1000);
    check_int("max_count_pulses", rises, 255);
    idle_cycles(1);

    // Reset mid-train drops outputs asynchronously and suppresses done.
    step(1'b1, 5, 2, 3, 1'b0);
    idle_cycles(2);
    resetn = 1'b0;
    have   = 1'b0;
    #1;
    check_bit("midreset_pulse", pulse_o, 1'b0);
    check_bit("midreset_busy", busy_o, 1'b0);
    idle_cycles(2);
    resetn = 1'b1;
    idle_cycles(12);
    step(1'b1, 2, 2, 2, 1'b0);
    idle_until_done(20);

`ifdef PULSE_GEN_ABORT_EN
    idle_cycles(2);
    step(1'b1, 3, 2, 2, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1);
    check_bit("abort_busy", busy_o, 1'b0);
    idle_cycles(10);
    step(1'b1, 3, 2, 2, 1'b1);
    check_bit("abort_start_ignored", busy_o, 1'b0);
    idle_cycles(2);
`endif

    // Random trains with random start noise while busy.
    for (int t = 0; t < 25; t++) begin
      int n;
      step(1'b1, int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
           int'($urandom_range(0, 5)), 1'b0);
      n = 0;
      model(cyc, p, b, d);
      while (b && n < 200) begin
        step(1'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
             int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 1'b0);
        model(cyc, p, b, d);
        n++;
      end
      check_bit("random_train_ends", b, 1'b0);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
